// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request bus between the fetch stage and instruction memory.
// Handshake: the master raises imem_req with imem_addr and holds both stable
// until a cycle in which the slave drives imem_ready=1; that cycle completes the
// transaction and imem_rdata is valid in it. Ready in the same cycle as the
// request rise (zero wait state) is legal.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs one outstanding imem
// transaction at a time and buffers returned words in a 2-entry queue whose
// head feeds IF/ID. Redirects from ID flush the queue and restart fetch.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  if_fetch_unit_if.master imem,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic [1:0]  o_dbg_state,
  output logic [1:0]  o_dbg_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_count;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_addr;
  logic [31:0] r_q_pc   [2];
  logic [31:0] r_q_inst [2];

  logic [31:0] w_fetch_pc_nxt;
  logic [31:0] w_addr_nxt;
  logic [31:0] w_addr_inc;
  logic [31:0] w_redirect_word;
  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_count_post;
  logic [1:0]  w_slot;

  // Fetch addresses are word aligned; the low two bits of a redirect target are ignored.
  assign w_redirect_word = redirect_pc & 32'hFFFF_FFFC;
  assign w_addr_inc      = r_addr + 32'd4;

  // A redirect suppresses both the push of completing data and the head pop.
  assign w_push = (r_state == REQ) && imem.imem_ready && !redirect;
  assign w_pop  = pc_write && (r_count != 2'd0) && !redirect;

  assign w_count_post = redirect ? 2'd0
                                 : (r_count + {1'b0, w_push} - {1'b0, w_pop});

  // New entries land behind whatever survives this cycle's pop.
  assign w_slot = w_pop ? (r_count - 2'd1) : r_count;

  assign imem.imem_req  = (r_state != IDLE);
  assign imem.imem_addr = r_addr;

  assign if_valid = (r_count != 2'd0);
  assign if_pc    = if_valid ? r_q_pc[0]   : 32'h0000_0000;
  assign if_inst  = if_valid ? r_q_inst[0] : NOP_INST;

  assign o_dbg_state = r_state;
  assign o_dbg_count = r_count;

  // Next-state, next request address and next fetch PC; redirect overrides everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_fetch_pc_nxt = r_fetch_pc;
    if (redirect) begin
      w_fetch_pc_nxt = w_redirect_word;
      if (r_state == IDLE || imem.imem_ready) begin
        // Nothing in flight, or the in-flight transaction ends now and its data is dropped.
        w_state_nxt = REQ;
        w_addr_nxt  = w_redirect_word;
      end else begin
        // Still waiting: finish the stale transaction first, then fetch the new path.
        w_state_nxt = DISCARD;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_count_post < 2'd2) begin
            w_state_nxt = REQ;
            w_addr_nxt  = r_fetch_pc;
          end
        end
        REQ: begin
          if (imem.imem_ready) begin
            w_fetch_pc_nxt = w_addr_inc;
            if (w_count_post < 2'd2) begin
              w_state_nxt = REQ;
              w_addr_nxt  = w_addr_inc;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
        DISCARD: begin
          if (imem.imem_ready) begin
            w_state_nxt = REQ;
            w_addr_nxt  = r_fetch_pc;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // FSM state, request address and fetch PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  // Queue storage: shift on pop, write the returned word {pc+4, inst} behind the survivors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= 2'd0;
      r_q_pc[0]   <= 32'h0000_0000;
      r_q_pc[1]   <= 32'h0000_0000;
      r_q_inst[0] <= NOP_INST;
      r_q_inst[1] <= NOP_INST;
    end else begin
      r_count <= w_count_post;
      if (w_pop) begin
        r_q_pc[0]   <= r_q_pc[1];
        r_q_inst[0] <= r_q_inst[1];
      end
      if (w_push) begin
        r_q_pc[w_slot[0]]   <= w_addr_inc;
        r_q_inst[w_slot[0]] <= imem.imem_rdata;
      end
    end
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline; sits directly upstream of the IF/ID pipeline register. Owns the fetch PC, issues requests to instruction memory over a req/ready handshake, and buffers returned instructions in a 2-entry queue. Presents one instruction per cycle to IF/ID as `if_pc`/`if_inst`. Supports hazard stalls through `pc_write` and branch/jump redirects resolved in ID.

## Interface
- `RESET_PC`, 32'h0000_0000: fetch address after reset.
- `NOP_INST`, 32'h0000_0000: instruction word driven when the queue is empty (bubble).

- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc_write`  in  1  hazard-unit enable; 1 = IF/ID captures the head entry this cycle (pop), 0 = stall.
- `redirect`  in  1  one-cycle pulse; branch/jump taken in ID.
- `redirect_pc`  in  32  new fetch address; valid with `redirect`.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  registered address of the current transaction.
- `imem_ready`  in  1  memory completes the transaction this cycle.
- `imem_rdata`  in  32  instruction word; valid when `imem_req && imem_ready`.
- `if_pc`  out  32  PC+4 of the head instruction; 0 when empty.
- `if_inst`  out  32  head instruction; `NOP_INST` when empty.
- `if_valid`  out  1  queue non-empty.

## Operation
- Queue: 2 entries of {pc+4, inst}; `count` 0..2. `if_*` are combinational from the head entry. Pop = `pc_write && count!=0 && !redirect`.
- At most one memory transaction outstanding. Word addresses only: `imem_addr[1:0]` always 00. PC arithmetic is modulo 2^32, so 0xFFFF_FFFC+4 wraps to 0.
- FSM states:
  - IDLE: `imem_req`=0. Go to REQ when the post-update count <2. `imem_addr` <= `fetch_pc` on this transition.
  - REQ: `imem_req`=1. On ready, push {`imem_addr`+4, `imem_rdata`} and set `fetch_pc` <= `imem_addr`+4. Next state is REQ if the post-update count <2 (with `imem_addr` <= new `fetch_pc`), else IDLE.
  - DISCARD: `imem_req`=1 with the stale address. On ready, drop the data and go to REQ with `imem_addr` <= `fetch_pc`.
- Handshake: once raised, `imem_req` and `imem_addr` stay stable until the cycle with `imem_ready`=1. Same-cycle ready (zero wait state) is legal.
- Redirect has priority over push, pop and stall, from any state:
  - Flush: count <= 0.
  - `fetch_pc` <= `redirect_pc`.
  - If a transaction is outstanding and not completing this cycle, go to DISCARD.
  - If it completes this cycle, drop its data and go to REQ with `imem_addr` <= `redirect_pc`.
  - From IDLE, go to REQ with `imem_addr` <= `redirect_pc`.
- A redirect while in DISCARD updates `fetch_pc` only; the state stays DISCARD.
- Push and pop in the same cycle with count=2 are not possible, because requests are issued only when count <2.

## Timing
- Reset values: state IDLE, count 0, `fetch_pc`=`RESET_PC`, `imem_addr`=`RESET_PC`, `imem_req`=0, `if_valid`=0, `if_inst`=`NOP_INST`, `if_pc`=0. All take effect immediately on `rst` assertion, including mid-transaction; any outstanding request is abandoned.
- First request: cycle 1 after `rst` release (IDLE -> REQ), address `RESET_PC`.
- Fetch latency: data accepted at posedge N appears on `if_inst` after that edge (cycle N+1).
- Throughput: 1 instruction/cycle with zero-wait memory and `pc_write`=1. With k wait cycles, 1 instruction per k+1 cycles.
- Stall: with `pc_write`=0 the queue fills to 2 and `imem_req` drops. Fetch resumes the cycle after the first pop, with no addresses skipped or duplicated.
- Redirect cycle: the head is not popped. From the next cycle, `if_valid`=0 and `if_inst`=`NOP_INST` until the first new-path instruction is pushed.

## Test plan
- Reset then `imem_ready`=1, `pc_write`=1, mem[i]=0x1000_0000+i: requests at 0x0, 0x4, 0x8 on consecutive cycles. `if_inst`=0x1000_0000 with `if_pc`=0x4 in cycle 2, then a new instruction every cycle.
- `pc_write`=0 for 6 cycles mid-stream: count reaches 2, `imem_req`=0, head unchanged. After release, `if_pc` continues 0xC, 0x10, ... with no gaps or repeats.
- `imem_ready` asserted 3 cycles after req: `imem_addr` stable across the wait; one instruction per 4 cycles; `if_valid` toggles accordingly.
- Redirect to 0x100 while the 0x8 request is waiting (ready low): next cycle `if_valid`=0 and `if_inst`=`NOP_INST`. The 0x8 data is dropped when ready arrives. Next request is 0x100; the first valid output has `if_pc`=0x104.
- Redirect to 0x200 in the same cycle as completion and `pc_write`=1: the completing data is not pushed, no pop occurs, count=0, and the next-cycle request address is 0x200.
- Async `rst` pulse between clock edges during an outstanding request: outputs return to reset values immediately. After release, fetch restarts at `RESET_PC`.
